spi_master_param: RTL and testbench

Parametrised SPI master that generalises the fixed 8-bit, single-mode SPI master: configurable word width, slave count and SCLK divider, plus per-transfer selection of all four SPI modes (CPOL/CPHA) and bit order. It sits between a local controller, which issues `start` with a word and a slave index, and up to `NUM_SLAVES` external SPI slaves. It adds explicit `busy`/`done` handshake outputs and a range check on the slave index.

---
 rtl/spi_master_param.sv | 239 +++++++++++++++++++++++
 tb/tb_spi_master_param.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master_param
//  Purpose  : Parametrised SPI master. Supports a configurable word width,
//             slave count and SCLK divider. CPOL, CPHA and bit order are
//             selected per transfer. A busy/done handshake is provided, and
//             slave indices outside the valid range are rejected.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                 in   system clock, rising edge
//    reset               in   asynchronous, active-high reset
//    start               in   transfer request, sampled while busy=0
//    cpol / cpha         in   SPI mode, latched at accept
//    lsb_first           in   1: bit 0 first, 0: MSB first, latched at accept
//    slaveSelect         in   target chip-select index, latched at accept
//    masterDataToSend    in   word to transmit, latched at accept
//    masterDataReceived  out  last complete received word
//    busy                out  high from accept until completion
//    done                out  one-cycle completion pulse
//    SCLK                out  serial clock
//    CS                  out  active-low chip selects
//    MOSI                out  serial data out
//    MISO                in   serial data in
// ============================================================================
module spi_master_param #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_SLAVES = 3,
   parameter int SS_WIDTH   = 2,
   parameter int CLK_DIV    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic                  lsb_first,
   input  logic [SS_WIDTH-1:0]   slaveSelect,
   input  logic [DATA_WIDTH-1:0] masterDataToSend,
   output logic [DATA_WIDTH-1:0] masterDataReceived,
   output logic                  busy,
   output logic                  done,
   output logic                  SCLK,
   output logic [NUM_SLAVES-1:0] CS,
   output logic                  MOSI,
   input  logic                  MISO
);

   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int HALF_W = $clog2(2 * DATA_WIDTH);
   localparam int BIT_W  = $clog2(DATA_WIDTH);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_WIDTH - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
   localparam logic [SS_WIDTH:0] NUM_SL    = (SS_WIDTH + 1)'(NUM_SLAVES);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LEAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [DIV_W-1:0]       div_q, div_d;
   logic [HALF_W-1:0]      half_q, half_d;
   logic [DATA_WIDTH-1:0]  tx_q, tx_d;
   logic [DATA_WIDTH-1:0]  rx_q, rx_d;
   logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
   logic                   cpol_q, cpol_d;
   logic                   cpha_q, cpha_d;
   logic                   lsb_q, lsb_d;
   logic                   sclk_q, sclk_d;
   logic                   mosi_q, mosi_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [NUM_SLAVES-1:0]  cs_q, cs_d;

   logic                   sel_ok;
   logic [HALF_W-1:0]      half_nx;
   logic [BIT_W-1:0]       cur_bit;

   // Logical bit number (0 = first on the wire) to physical bit position.
   function automatic logic [BIT_W-1:0] bit_pos(input logic [BIT_W-1:0] idx,
                                                input logic             lsb);
      return lsb ? idx : (BIT_LAST - idx);
   endfunction

   assign sel_ok = ({1'b0, slaveSelect} < NUM_SL);

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      half_d  = half_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      rdata_d = rdata_q;
      cpol_d  = cpol_q;
      cpha_d  = cpha_q;
      lsb_d   = lsb_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cs_d    = cs_q;
      half_nx = half_q + 1'b1;
      // Half-period index h covers bit h/2; even h is a leading edge.
      cur_bit = half_nx[HALF_W-1:1];

      case (state_q)
         ST_IDLE: begin
            sclk_d = cpol;
            if (start && sel_ok) begin
               state_d = ST_LEAD;
               div_d   = '0;
               half_d  = '0;
               tx_d    = masterDataToSend;
               rx_d    = '0;
               cpol_d  = cpol;
               cpha_d  = cpha;
               lsb_d   = lsb_first;
               busy_d  = 1'b1;
               cs_d    = ~(NUM_SLAVES'(1) << slaveSelect);
               // CPHA=0 presents the first bit before the first leading edge.
               mosi_d  = cpha ? 1'b0 : masterDataToSend[bit_pos('0, lsb_first)];
            end
         end

         ST_LEAD: begin
            if (div_q == DIV_LAST) begin
               state_d = ST_SHIFT;
               div_d   = '0;
               half_d  = '0;
               sclk_d  = ~cpol_q;
               if (cpha_q) begin
                  mosi_d = tx_q[bit_pos('0, lsb_q)];
               end else begin
                  rx_d[bit_pos('0, lsb_q)] = MISO;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end

         ST_SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (half_q == HALF_LAST) begin
                  // Last trailing edge already issued; SCLK rests at cpol.
                  state_d = ST_HOLD;
               end else begin
                  half_d = half_nx;
                  sclk_d = ~sclk_q;
                  if (half_nx[0]) begin
                     // Trailing edge
                     if (cpha_q) begin
                        rx_d[bit_pos(cur_bit, lsb_q)] = MISO;
                     end else if (cur_bit != BIT_LAST) begin
                        mosi_d = tx_q[bit_pos(cur_bit + 1'b1, lsb_q)];
                     end
                  end else begin
                     // Leading edge
                     if (cpha_q) begin
                        mosi_d = tx_q[bit_pos(cur_bit, lsb_q)];
                     end else begin
                        rx_d[bit_pos(cur_bit, lsb_q)] = MISO;
                     end
                  end
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end

         ST_HOLD: begin
            if (div_q == DIV_LAST) begin
               state_d = ST_IDLE;
               div_d   = '0;
               cs_d    = '1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               sclk_d  = cpol_q;
               mosi_d  = 1'b0;
               rdata_d = rx_q;
            end else begin
               div_d = div_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
         half_q  <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         rdata_q <= '0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         lsb_q   <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cs_q    <= '1;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         half_q  <= half_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
         cpol_q  <= cpol_d;
         cpha_q  <= cpha_d;
         lsb_q   <= lsb_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cs_q    <= cs_d;
      end
   end

   assign masterDataReceived = rdata_q;
   assign busy               = busy_q;
   assign done               = done_q;
   assign SCLK               = sclk_q;
   assign CS                 = cs_q;
   assign MOSI               = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master_param
//  Purpose  : Self-checking bench for spi_master_param. Two instances: the
//             default configuration (A) and a 16-bit / 5-slave / CLK_DIV=3
//             configuration (B), each with a loopback SPI slave model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_master_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   // ---------------- instance A: default parameters ----------------
   logic       a_start, a_cpol, a_cpha, a_lsb, a_miso;
   logic [1:0] a_ss;
   logic [7:0] a_tx, a_rd;
   logic       a_busy, a_done, a_sclk, a_mosi;
   logic [2:0] a_cs;

   spi_master_param u_a (
      .clk(clk), .reset(reset), .start(a_start), .cpol(a_cpol), .cpha(a_cpha),
      .lsb_first(a_lsb), .slaveSelect(a_ss), .masterDataToSend(a_tx),
      .masterDataReceived(a_rd), .busy(a_busy), .done(a_done), .SCLK(a_sclk),
      .CS(a_cs), .MOSI(a_mosi), .MISO(a_miso)
   );

   // ---------------- instance B: 16 bit, 5 slaves, CLK_DIV 3 ----------------
   logic        b_start, b_cpol, b_cpha, b_lsb, b_miso;
   logic [2:0]  b_ss;
   logic [15:0] b_tx, b_rd;
   logic        b_busy, b_done, b_sclk, b_mosi;
   logic [4:0]  b_cs;

   spi_master_param #(.DATA_WIDTH(16), .NUM_SLAVES(5), .SS_WIDTH(3), .CLK_DIV(3)) u_b (
      .clk(clk), .reset(reset), .start(b_start), .cpol(b_cpol), .cpha(b_cpha),
      .lsb_first(b_lsb), .slaveSelect(b_ss), .masterDataToSend(b_tx),
      .masterDataReceived(b_rd), .busy(b_busy), .done(b_done), .SCLK(b_sclk),
      .CS(b_cs), .MOSI(b_mosi), .MISO(b_miso)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
   endtask

   function automatic int bpos(input int k, input logic lsb, input int w);
      return lsb ? k : (w - 1 - k);
   endfunction

   // ---------------- loopback slave model for A ----------------
   logic [7:0] sa_tx, sa_rx;
   logic       sa_cpol, sa_cpha, sa_lsb;
   int         sa_rc, sa_dc;
   int         a_rise;
   logic       a_act;
   logic       sa_act_p = 1'b0, sa_sclk_p = 1'b0;
   assign a_act = (a_cs != 3'b111);

   always @(a_sclk or a_act) begin
      if (a_act && !sa_act_p) begin
         sa_rc = 0;
         sa_rx = '0;
         if (!sa_cpha) begin a_miso = sa_tx[bpos(0, sa_lsb, 8)]; sa_dc = 1; end
         else sa_dc = 0;
      end else if (a_act && (a_sclk != sa_sclk_p)) begin
         if ((a_sclk != sa_cpol) != sa_cpha) begin
            if (sa_rc < 8) sa_rx[bpos(sa_rc, sa_lsb, 8)] = a_mosi;
            sa_rc++;
         end else begin
            if (sa_dc < 8) a_miso = sa_tx[bpos(sa_dc, sa_lsb, 8)];
            sa_dc++;
         end
      end
      sa_act_p  = a_act;
      sa_sclk_p = a_sclk;
   end

   always @(posedge a_sclk) if (a_cs[1] == 1'b0) a_rise++;

   // ---------------- loopback slave model for B ----------------
   logic [15:0] sb_tx, sb_rx;
   logic        sb_cpol, sb_cpha, sb_lsb;
   int          sb_rc, sb_dc;
   logic        b_act;
   logic        sb_act_p = 1'b0, sb_sclk_p = 1'b0;
   assign b_act = (b_cs != 5'b11111);

   always @(b_sclk or b_act) begin
      if (b_act && !sb_act_p) begin
         sb_rc = 0;
         sb_rx = '0;
         if (!sb_cpha) begin b_miso = sb_tx[bpos(0, sb_lsb, 16)]; sb_dc = 1; end
         else sb_dc = 0;
      end else if (b_act && (b_sclk != sb_sclk_p)) begin
         if ((b_sclk != sb_cpol) != sb_cpha) begin
            if (sb_rc < 16) sb_rx[bpos(sb_rc, sb_lsb, 16)] = b_mosi;
            sb_rc++;
         end else begin
            if (sb_dc < 16) b_miso = sb_tx[bpos(sb_dc, sb_lsb, 16)];
            sb_dc++;
         end
      end
      sb_act_p  = b_act;
      sb_sclk_p = b_sclk;
   end

   // One transfer on A. Edges are numbered from the accept edge (0).
   task automatic run_a(input logic pol, input logic pha, input logic lsb,
                        input logic [1:0] ss, input logic [7:0] tx, input logic [7:0] stx,
                        input int poke, output int dedge, output logic [2:0] cs_acc,
                        output logic [2:0] cs_mid, output logic [7:0] rd_mid,
                        output logic busy_acc, output logic idle_sclk);
      sa_cpol = pol; sa_cpha = pha; sa_lsb = lsb; sa_tx = stx;
      a_cpol = pol; a_cpha = pha; a_lsb = lsb; a_ss = ss; a_tx = tx;
      @(posedge clk); #1;
      idle_sclk = a_sclk;
      a_rise  = 0;
      a_start = 1'b1;
      @(posedge clk); #1;
      a_start  = 1'b0;
      cs_acc   = a_cs;
      busy_acc = a_busy;
      dedge    = -1;
      cs_mid   = '1;
      rd_mid   = '0;
      for (int e = 1; e <= 60; e++) begin
         @(posedge clk); #1;
         if (e == poke) begin
            // Request and input changes while busy must be ignored.
            a_start = 1'b1; a_tx = ~tx; a_ss = 2'd2;
            a_cpha = ~pha; a_cpol = ~pol; a_lsb = ~lsb;
         end else begin
            a_start = 1'b0;
         end
         if (e == 9) begin cs_mid = a_cs; rd_mid = a_rd; end
         if (a_done) begin dedge = e; break; end
      end
      a_start = 1'b0;
   endtask

   int         dedge, d1, d2, first_t, second_t;
   logic [2:0] cs_acc, cs_mid;
   logic [4:0] b_cs_acc, b_cs_mid;
   logic [7:0] rd_mid;
   logic       busy_acc, idle_sclk, saw_busy, saw_done, saw_cs, hold_ok, prev;

   initial begin
      reset = 1'b1;
      a_start = 0; a_cpol = 0; a_cpha = 0; a_lsb = 0; a_ss = '0; a_tx = '0; a_miso = 0;
      b_start = 0; b_cpol = 0; b_cpha = 0; b_lsb = 0; b_ss = '0; b_tx = '0; b_miso = 0;
      sa_cpol = 0; sa_cpha = 0; sa_lsb = 0; sa_tx = '0; sa_rx = '0; sa_rc = 0; sa_dc = 0;
      sb_cpol = 0; sb_cpha = 0; sb_lsb = 0; sb_tx = '0; sb_rx = '0; sb_rc = 0; sb_dc = 0;
      a_rise = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_sclk", a_sclk, 0);
      check("rst_cs",   a_cs, 3'b111);
      check("rst_mosi", a_mosi, 0);
      check("rst_busy", a_busy, 0);
      check("rst_done", a_done, 0);
      check("rst_rdata", a_rd, 8'h00);
      check("rst_b_cs", b_cs, 5'b11111);
      reset = 1'b0;

      // Mode 0, LSB first, slave 1
      run_a(0, 0, 1, 2'd1, 8'h01, 8'h02, -1, dedge, cs_acc, cs_mid, rd_mid, busy_acc, idle_sclk);
      check("t1_busy_acc", busy_acc, 1);
      check("t1_cs_acc", cs_acc, 3'b101);
      check("t1_cs_mid", cs_mid, 3'b101);
      check("t1_rd_mid", rd_mid, 8'h00);
      check("t1_done_edge", dedge, 18);
      check("t1_rdata", a_rd, 8'h02);
      check("t1_slave_rx", sa_rx, 8'h01);
      check("t1_rises", a_rise, 8);
      check("t1_cs_rel", a_cs, 3'b111);
      check("t1_busy_end", a_busy, 0);
      @(posedge clk); #1;
      check("t1_done_pulse", a_done, 0);

      // All four modes, MSB first
      for (int m = 0; m < 4; m++) begin
         run_a(m[1], m[0], 0, 2'd0, 8'hA5, 8'h3C, -1, dedge, cs_acc, cs_mid, rd_mid, busy_acc, idle_sclk);
         check($sformatf("mode%0d_idle_sclk", m), idle_sclk, m[1]);
         check($sformatf("mode%0d_done_edge", m), dedge, 18);
         check($sformatf("mode%0d_rdata", m), a_rd, 8'h3C);
         check($sformatf("mode%0d_slave_rx", m), sa_rx, 8'hA5);
         check($sformatf("mode%0d_sclk_end", m), a_sclk, m[1]);
      end

      // Invalid slave index: no busy, no CS, no done
      a_ss = 2'd3; a_tx = 8'h77; a_start = 1'b1;
      saw_busy = 0; saw_done = 0; saw_cs = 0;
      for (int e = 0; e < 25; e++) begin
         @(posedge clk); #1;
         if (e == 3) a_start = 1'b0;
         if (a_busy) saw_busy = 1;
         if (a_done) saw_done = 1;
         if (a_cs != 3'b111) saw_cs = 1;
      end
      check("bad_ss_busy", saw_busy, 0);
      check("bad_ss_done", saw_done, 0);
      check("bad_ss_cs", saw_cs, 0);

      // Start and input changes mid-transfer are ignored
      run_a(0, 0, 0, 2'd1, 8'h5A, 8'hC3, 5, dedge, cs_acc, cs_mid, rd_mid, busy_acc, idle_sclk);
      check("poke_cs_mid", cs_mid, 3'b101);
      check("poke_done_edge", dedge, 18);
      check("poke_rdata", a_rd, 8'hC3);
      check("poke_slave_rx", sa_rx, 8'h5A);
      repeat (2) @(posedge clk);
      #1;
      check("poke_no_queue", a_busy, 0);

      // Back-to-back with start held high
      sa_cpol = 0; sa_cpha = 0; sa_lsb = 0; sa_tx = 8'h00;
      a_cpol = 0; a_cpha = 0; a_lsb = 0; a_ss = 2'd1; a_tx = 8'hFF;
      @(posedge clk); #1;
      a_start = 1'b1;
      @(posedge clk); #1;
      a_tx = 8'h00;
      d1 = -1;
      for (int e = 1; e <= 60; e++) begin
         @(posedge clk); #1;
         if (a_done) begin d1 = e; break; end
      end
      check("b2b_done1_edge", d1, 18);
      check("b2b_rdata1", a_rd, 8'h00);
      check("b2b_slave_rx1", sa_rx, 8'hFF);
      sa_tx = 8'hFF;
      @(posedge clk); #1;
      check("b2b_accept2", a_busy, 1);
      a_start = 1'b0;
      d2 = -1; hold_ok = 1;
      for (int e = 1; e <= 60; e++) begin
         @(posedge clk); #1;
         if (a_done) begin d2 = e; break; end
         if (a_rd !== 8'h00) hold_ok = 0;
      end
      check("b2b_done2_edge", d2, 18);
      check("b2b_rdata_hold", hold_ok, 1);
      check("b2b_rdata2", a_rd, 8'hFF);
      check("b2b_slave_rx2", sa_rx, 8'h00);

      // Reset at edge 7 of a transfer
      sa_cpol = 0; sa_cpha = 0; sa_lsb = 0; sa_tx = 8'h55;
      a_cpol = 0; a_cpha = 0; a_lsb = 0; a_ss = 2'd0; a_tx = 8'h5A;
      @(posedge clk); #1;
      a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      check("pre_rst_sclk", a_sclk, 1);
      reset = 1'b1;
      #1;
      check("mid_rst_cs", a_cs, 3'b111);
      check("mid_rst_sclk", a_sclk, 0);
      check("mid_rst_busy", a_busy, 0);
      check("mid_rst_rdata", a_rd, 8'h00);
      check("mid_rst_mosi", a_mosi, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      saw_done = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (a_done) saw_done = 1;
      end
      check("mid_rst_no_done", saw_done, 0);
      run_a(0, 0, 0, 2'd0, 8'h0F, 8'hF0, -1, dedge, cs_acc, cs_mid, rd_mid, busy_acc, idle_sclk);
      check("post_rst_done_edge", dedge, 18);
      check("post_rst_rdata", a_rd, 8'hF0);
      check("post_rst_slave_rx", sa_rx, 8'h0F);

      // Instance B: 16 bit, CLK_DIV 3, slave 4
      sb_cpol = 0; sb_cpha = 0; sb_lsb = 0; sb_tx = 16'h7FFE;
      b_cpol = 0; b_cpha = 0; b_lsb = 0; b_ss = 3'd4; b_tx = 16'h8001;
      @(posedge clk); #1;
      b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      b_cs_acc = b_cs;
      b_cs_mid = '1;
      first_t = -1; second_t = -1; dedge = -1;
      prev = b_sclk;
      for (int e = 1; e <= 150; e++) begin
         @(posedge clk); #1;
         if (b_sclk != prev) begin
            if (first_t < 0) first_t = e;
            else if (second_t < 0) second_t = e;
         end
         prev = b_sclk;
         if (e == 50) b_cs_mid = b_cs;
         if (b_done) begin dedge = e; break; end
      end
      check("b_cs_acc", b_cs_acc, 5'b01111);
      check("b_cs_mid", b_cs_mid, 5'b01111);
      check("b_first_edge", first_t, 3);
      check("b_second_edge", second_t, 6);
      check("b_done_edge", dedge, 102);
      check("b_rdata", b_rd, 16'h7FFE);
      check("b_slave_rx", sb_rx, 16'h8001);
      check("b_cs_rel", b_cs, 5'b11111);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
